// File: rtl/fpu_result_mux_if.sv
// Handshake and data bundle between the FPU arithmetic units, the result mux and its consumer.
// The master side drives requests and unit results; the slave side is the result mux itself.
interface fpu_result_mux_if #(
   parameter int WIDTH   = 32,
   parameter int N_UNITS = 4,
   parameter int OP_W    = 3,
   parameter int CNT_W   = 16
);
   logic                       op_valid;
   logic                       op_ready;
   logic [OP_W-1:0]            operation;
   logic [N_UNITS-1:0]         unit_valid;
   logic [N_UNITS*WIDTH-1:0]   unit_data;
   logic                       cmp_valid;
   logic                       equal;
   logic                       greater;
   logic                       lesser;
   logic                       out_valid;
   logic                       out_ready;
   logic [WIDTH-1:0]           Out;
   logic                       equal_out;
   logic                       greater_out;
   logic                       lesser_out;
   logic                       out_illegal;
   logic                       out_timeout;
   logic [CNT_W-1:0]           result_count;

   modport master (
      output op_valid, operation, unit_valid, unit_data,
      output cmp_valid, equal, greater, lesser, out_ready,
      input  op_ready, out_valid, Out, equal_out, greater_out, lesser_out,
      input  out_illegal, out_timeout, result_count
   );

   modport slave (
      input  op_valid, operation, unit_valid, unit_data,
      input  cmp_valid, equal, greater, lesser, out_ready,
      output op_ready, out_valid, Out, equal_out, greater_out, lesser_out,
      output out_illegal, out_timeout, result_count
   );
endinterface

// File: rtl/fpu_result_mux.sv
// Registered FPU result selector: accepts an op code, waits for the chosen unit or comparator,
// captures its result and holds it until the consumer takes it; counts consumed results.
module fpu_result_mux #(
   parameter int WIDTH   = 32,
   parameter int N_UNITS = 4,
   parameter int OP_W    = 3,
   parameter int CMP_OP  = 4,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   fpu_result_mux_if.slave   bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam int              WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [OP_W-1:0] CMP_CODE = OP_W'(CMP_OP);
   localparam logic [OP_W-1:0] UNIT_LIM = OP_W'(N_UNITS);
   localparam logic [WD_W-1:0] WD_LAST  = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   logic [1:0]        r_state;
   logic [OP_W-1:0]   r_sel;
   logic [WD_W-1:0]   r_wdog;
   logic [WIDTH-1:0]  r_out;
   logic              r_eq;
   logic              r_gt;
   logic              r_lt;
   logic              r_illegal;
   logic              r_timeout;
   logic [CNT_W-1:0]  r_count;

   logic [N_UNITS-1:0] w_hit;
   logic [WIDTH-1:0]   w_slice [N_UNITS];
   logic [WIDTH-1:0]   w_unit_data;
   logic               w_unit_valid;
   logic               w_is_cmp;
   logic               w_sel_valid;
   logic               w_op_ready;
   logic               w_accept;
   logic               w_op_legal;
   logic               w_wd_expire;

   // One-hot decode of the registered selector; unselected slices are zeroed so an OR-tree muxes them.
   for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_unit
      assign w_hit[gi]   = (r_sel == OP_W'(gi));
      assign w_slice[gi] = w_hit[gi] ? bus.unit_data[gi*WIDTH +: WIDTH] : '0;
   end

   always_comb begin
      w_unit_data = '0;
      for (int k = 0; k < N_UNITS; k++) begin
         w_unit_data = w_unit_data | w_slice[k];
      end
   end

   assign w_unit_valid = |(w_hit & bus.unit_valid);
   assign w_is_cmp     = (r_sel == CMP_CODE);
   assign w_sel_valid  = w_is_cmp ? bus.cmp_valid : w_unit_valid;
   assign w_op_ready   = (r_state == S_IDLE) && !rst;
   assign w_accept     = bus.op_valid && w_op_ready;
   assign w_op_legal   = (bus.operation < UNIT_LIM) || (bus.operation == CMP_CODE);
   assign w_wd_expire  = (TIMEOUT != 0) && (r_wdog == WD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_sel     <= '0;
         r_wdog    <= '0;
         r_out     <= '0;
         r_eq      <= 1'b0;
         r_gt      <= 1'b0;
         r_lt      <= 1'b0;
         r_illegal <= 1'b0;
         r_timeout <= 1'b0;
         r_count   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_sel     <= bus.operation;
                  r_illegal <= 1'b0;
                  r_timeout <= 1'b0;
                  if (w_op_legal) begin
                     r_state <= S_WAIT;
                     r_wdog  <= '0;
                  end else begin
                     // Unknown op codes skip the wait and are reported straight away.
                     r_state   <= S_HOLD;
                     r_illegal <= 1'b1;
                     r_out     <= '0;
                     r_eq      <= 1'b0;
                     r_gt      <= 1'b0;
                     r_lt      <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               if (w_sel_valid) begin
                  r_state <= S_HOLD;
                  if (w_is_cmp) begin
                     r_out <= '0;
                     r_eq  <= bus.equal;
                     r_gt  <= bus.greater;
                     r_lt  <= bus.lesser;
                  end else begin
                     r_out <= w_unit_data;
                     r_eq  <= 1'b0;
                     r_gt  <= 1'b0;
                     r_lt  <= 1'b0;
                  end
               end else if (w_wd_expire) begin
                  r_state   <= S_HOLD;
                  r_timeout <= 1'b1;
                  r_out     <= '0;
                  r_eq      <= 1'b0;
                  r_gt      <= 1'b0;
                  r_lt      <= 1'b0;
               end else begin
                  r_wdog <= r_wdog + WD_W'(1);
               end
            end
            S_HOLD: begin
               if (bus.out_ready) begin
                  r_state <= S_IDLE;
                  r_count <= r_count + CNT_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.op_ready     = w_op_ready;
   assign bus.out_valid    = (r_state == S_HOLD);
   assign bus.Out          = r_out;
   assign bus.equal_out    = r_eq;
   assign bus.greater_out  = r_gt;
   assign bus.lesser_out   = r_lt;
   assign bus.out_illegal  = r_illegal;
   assign bus.out_timeout  = r_timeout;
   assign bus.result_count = r_count;

endmodule

// File: tb/tb_fpu_result_mux.sv
// Directed bench for fpu_result_mux with TIMEOUT=4 and a 4-bit result counter.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fpu_result_mux;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fpu_result_mux_if #(.WIDTH(32), .N_UNITS(4), .OP_W(3), .CNT_W(4)) bus ();

   fpu_result_mux #(
      .WIDTH(32), .N_UNITS(4), .OP_W(3), .CMP_OP(4), .TIMEOUT(4), .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic [2:0] exp);
      chk(tag, {61'd0, bus.equal_out, bus.greater_out, bus.lesser_out}, {61'd0, exp});
   endtask

   logic [31:0] held;

   initial begin
      rst            = 1'b1;
      bus.op_valid   = 1'b0;
      bus.operation  = '0;
      bus.unit_valid = '0;
      bus.unit_data  = '0;
      bus.cmp_valid  = 1'b0;
      bus.equal      = 1'b0;
      bus.greater    = 1'b0;
      bus.lesser     = 1'b0;
      bus.out_ready  = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_op_ready", 64'(bus.op_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out", 64'(bus.Out), 64'd0);
      chk_flags("rst_flags", 3'b000);
      chk("rst_status", {62'd0, bus.out_illegal, bus.out_timeout}, 64'd0);
      chk("rst_count", 64'(bus.result_count), 64'd0);
      rst = 1'b0;
      step();
      chk("post_rst_op_ready", 64'(bus.op_ready), 64'd1);

      // Unit op 2, result on the 3rd WAIT cycle, consumer ready
      $display("txn: op 2 unit result");
      bus.op_valid  = 1'b1;
      bus.operation = 3'd2;
      step();
      bus.op_valid  = 1'b0;
      chk("u2_op_ready_wait", 64'(bus.op_ready), 64'd0);
      bus.unit_valid = 4'b0010;
      bus.unit_data[32 +: 32] = 32'h11111111;
      step();
      chk("u2_ignore_unit1", 64'(bus.out_valid), 64'd0);
      bus.unit_valid = 4'b0000;
      step();
      bus.unit_valid = 4'b0100;
      bus.unit_data[64 +: 32] = 32'h40490FDB;
      bus.out_ready  = 1'b1;
      step();
      bus.unit_valid = 4'b0000;
      chk("u2_out_valid", 64'(bus.out_valid), 64'd1);
      chk("u2_out", 64'(bus.Out), 64'h40490FDB);
      chk_flags("u2_flags", 3'b000);
      chk("u2_count_before", 64'(bus.result_count), 64'd0);
      step();
      chk("u2_out_valid_1cyc", 64'(bus.out_valid), 64'd0);
      chk("u2_count", 64'(bus.result_count), 64'd1);
      chk("u2_op_ready_back", 64'(bus.op_ready), 64'd1);

      // Comparator op with a concurrent unit 0 valid
      $display("txn: op 4 compare greater");
      bus.out_ready = 1'b0;
      bus.op_valid  = 1'b1;
      bus.operation = 3'd4;
      step();
      bus.op_valid   = 1'b0;
      bus.cmp_valid  = 1'b1;
      bus.greater    = 1'b1;
      bus.unit_valid = 4'b0001;
      bus.unit_data[0 +: 32] = 32'hDEADBEEF;
      step();
      bus.cmp_valid  = 1'b0;
      bus.greater    = 1'b0;
      bus.unit_valid = 4'b0000;
      chk("cmp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("cmp_out", 64'(bus.Out), 64'd0);
      chk_flags("cmp_flags", 3'b010);
      bus.out_ready = 1'b1;
      step();
      chk("cmp_count", 64'(bus.result_count), 64'd2);

      // Illegal op 7
      $display("txn: op 7 illegal");
      bus.out_ready = 1'b0;
      bus.op_valid  = 1'b1;
      bus.operation = 3'd7;
      step();
      bus.op_valid = 1'b0;
      chk("ill_out_valid", 64'(bus.out_valid), 64'd1);
      chk("ill_status", {62'd0, bus.out_illegal, bus.out_timeout}, 64'b10);
      chk("ill_out", 64'(bus.Out), 64'd0);
      chk_flags("ill_flags", 3'b000);
      chk("ill_op_ready", 64'(bus.op_ready), 64'd0);
      step();
      chk("ill_op_ready_hold", 64'(bus.op_ready), 64'd0);
      chk("ill_out_valid_hold", 64'(bus.out_valid), 64'd1);
      bus.out_ready = 1'b1;
      step();
      chk("ill_count", 64'(bus.result_count), 64'd3);

      // Timeout: op 1 never gets its valid (unit 0 chatter must be ignored)
      $display("txn: op 1 timeout");
      bus.out_ready = 1'b0;
      bus.op_valid  = 1'b1;
      bus.operation = 3'd1;
      step();
      bus.op_valid   = 1'b0;
      bus.unit_valid = 4'b0001;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("to_wait_%0d", i), 64'(bus.out_valid), 64'd0);
         step();
      end
      bus.unit_valid = 4'b0000;
      chk("to_out_valid", 64'(bus.out_valid), 64'd1);
      chk("to_status", {62'd0, bus.out_illegal, bus.out_timeout}, 64'b01);
      chk("to_out", 64'(bus.Out), 64'd0);
      bus.out_ready = 1'b1;
      step();
      chk("to_count", 64'(bus.result_count), 64'd4);

      // Valid on the 4th WAIT cycle wins over the watchdog, then backpressure
      $display("txn: op 1 late valid with backpressure");
      bus.out_ready = 1'b0;
      bus.op_valid  = 1'b1;
      bus.operation = 3'd1;
      step();
      bus.op_valid = 1'b0;
      step();
      step();
      step();
      chk("late_wait4", 64'(bus.out_valid), 64'd0);
      bus.unit_valid = 4'b0010;
      bus.unit_data[32 +: 32] = 32'h3F800000;
      step();
      chk("late_out_valid", 64'(bus.out_valid), 64'd1);
      chk("late_out", 64'(bus.Out), 64'h3F800000);
      chk("late_status", {62'd0, bus.out_illegal, bus.out_timeout}, 64'b00);
      held = 32'h3F800000;
      bus.unit_valid = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < 4; k++) begin
            bus.unit_data[k*32 +: 32] = $urandom;
         end
         step();
         chk($sformatf("bp_out_%0d", i), 64'(bus.Out), 64'(held));
         chk($sformatf("bp_op_ready_%0d", i), 64'(bus.op_ready), 64'd0);
         chk($sformatf("bp_count_%0d", i), 64'(bus.result_count), 64'd4);
      end
      bus.unit_valid = 4'b0000;
      bus.out_ready  = 1'b1;
      step();
      chk("bp_released", 64'(bus.out_valid), 64'd0);
      chk("bp_count", 64'(bus.result_count), 64'd5);

      // Reset while in WAIT abandons the op
      $display("txn: op 0 abandoned by reset");
      bus.out_ready = 1'b0;
      bus.op_valid  = 1'b1;
      bus.operation = 3'd0;
      step();
      bus.op_valid = 1'b0;
      rst = 1'b1;
      step();
      chk("rstw_op_ready", 64'(bus.op_ready), 64'd0);
      rst = 1'b0;
      bus.unit_valid = 4'b0001;
      bus.out_ready  = 1'b1;
      step();
      bus.unit_valid = 4'b0000;
      chk("rstw_no_result", 64'(bus.out_valid), 64'd0);
      chk("rstw_count", 64'(bus.result_count), 64'd0);

      // 16 consumed results wrap the 4-bit counter to 0
      for (int k = 0; k < 16; k++) begin
         $display("txn: wrap op 5 #%0d", k);
         bus.op_valid  = 1'b1;
         bus.operation = 3'd5;
         step();
         bus.op_valid = 1'b0;
         chk($sformatf("wrap_valid_%0d", k), 64'(bus.out_valid), 64'd1);
         step();
         chk($sformatf("wrap_count_%0d", k), 64'(bus.result_count), 64'((k + 1) % 16));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
